// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared definitions for the instruction fetch stage: default
//               widths, opcode field layout and constants, FSM state type.
//               Prefetch mode is selected with the FETCH_PREFETCH_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int PC_W_DEFAULT    = 8;
    localparam int INSTR_W_DEFAULT = 16;

    // Opcode is the top OPC_W bits of the instruction word: instr[INSTR_W-1 -: OPC_W]
    localparam int OPC_W = 3;

    localparam logic [OPC_W-1:0] OP_LOAD  = 3'b000;
    localparam logic [OPC_W-1:0] OP_STORE = 3'b100;

    // Depth of the prefetch buffer
    localparam int FIFO_DEPTH = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_buffer
// Description : Two-entry FIFO between instruction memory and decode, used in
//               prefetch mode (FETCH_PREFETCH_EN). Flush empties it in one edge.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_flush,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty
);

    logic [W-1:0] r_mem [FIFO_DEPTH];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;
    logic         w_do_push;
    logic         w_do_pop;

    assign o_full    = (r_count == 2'(FIFO_DEPTH));
    assign o_empty   = (r_count == 2'd0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rd_ptr];

    // Storage, pointers and occupancy; a simultaneous push and pop keeps the count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction fetch stage. Requests words from instruction
//               memory and presents them to decode with a valid/ready
//               handshake. Redirect flushes and restarts at a new PC.
//               Define FETCH_PREFETCH_EN for the 2-entry prefetch variant.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int               PC_W     = PC_W_DEFAULT,
    parameter int               INSTR_W  = INSTR_W_DEFAULT,
    parameter logic [PC_W-1:0]  RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc,
    output logic [OPC_W-1:0]   op_code
);

    localparam logic [PC_W-1:0] c_pc_one = {{(PC_W-1){1'b0}}, 1'b1};

    fetch_state_t    r_state;
    logic [PC_W-1:0] r_pc;

    assign imem_addr = r_pc;
    assign op_code   = instr[INSTR_W-1 -: OPC_W];

`ifdef FETCH_PREFETCH_EN

    logic                    w_push;
    logic                    w_pop;
    logic                    w_full;
    logic                    w_empty;
    logic [PC_W+INSTR_W-1:0] w_head;

    // Keep requesting while the buffer has room; accepted words enter the FIFO
    assign imem_req    = (r_state != S_IDLE) && !w_full;
    assign w_push      = imem_req && imem_ack && !redirect_valid;
    assign instr_valid = !w_empty;
    assign w_pop       = instr_valid && instr_ready && !redirect_valid;
    assign {instr_pc, instr} = w_head;

    // Control state and fetch address; a redirect empties the FIFO on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
        end else if (redirect_valid) begin
            r_state <= S_REQ;
            r_pc    <= redirect_pc;
        end else begin
            if (r_state == S_IDLE) begin
                r_state <= S_REQ;
            end
            if (w_push) begin
                r_pc <= r_pc + c_pc_one;
            end
        end
    end

    fetch_buffer #(
        .W (PC_W + INSTR_W)
    ) u_fetch_buffer (
        .clk     (clk),
        .rst     (rst),
        .i_flush (redirect_valid),
        .i_push  (w_push),
        .i_data  ({r_pc, imem_rdata}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

`else

    logic               r_imem_req;
    logic               r_instr_valid;
    logic [INSTR_W-1:0] r_instr;
    logic [PC_W-1:0]    r_instr_pc;

    assign imem_req    = r_imem_req;
    assign instr_valid = r_instr_valid;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;

    // One-deep fetch FSM: request, capture on ack, hold for decode, repeat
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_imem_req    <= 1'b0;
            r_instr_valid <= 1'b0;
            r_instr       <= '0;
            r_instr_pc    <= '0;
        end else if (redirect_valid) begin
            // Any ack or ready in this cycle is dropped
            r_state       <= S_REQ;
            r_pc          <= redirect_pc;
            r_imem_req    <= 1'b1;
            r_instr_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state    <= S_REQ;
                    r_imem_req <= 1'b1;
                end
                S_REQ: begin
                    if (imem_ack) begin
                        r_instr       <= imem_rdata;
                        r_instr_pc    <= r_pc;
                        r_pc          <= r_pc + c_pc_one;
                        r_state       <= S_HOLD;
                        r_imem_req    <= 1'b0;
                        r_instr_valid <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (instr_ready) begin
                        r_state       <= S_REQ;
                        r_imem_req    <= 1'b1;
                        r_instr_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_imem_req    <= 1'b0;
                    r_instr_valid <= 1'b0;
                end
            endcase
        end
    end

`endif

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter PC_W, default 8, program-counter width in words.
REQ-002 SHALL have parameter INSTR_W, default 16, instruction width.
REQ-003 SHALL have parameter RESET_PC, default 0, first fetch address.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port imem_req  output  1  instruction-memory request.
REQ-007 SHALL have port imem_addr  output  PC_W  word address of the request.
REQ-008 SHALL have port imem_ack  input  1  response valid, data on imem_rdata in the same cycle.
REQ-009 SHALL have port imem_rdata  input  INSTR_W  fetched instruction.
REQ-010 SHALL have port redirect_valid  input  1  flush and restart at redirect_pc.
REQ-011 SHALL have port redirect_pc  input  PC_W  restart address.
REQ-012 SHALL have port instr_valid  output  1  instruction presented to decode.
REQ-013 SHALL have port instr_ready  input  1  decode accepts the presented instruction.
REQ-014 SHALL have port instr  output  INSTR_W  presented instruction.
REQ-015 SHALL have port instr_pc  output  PC_W  address of the presented instruction.
REQ-016 SHALL have port op_code  output  3  instr[INSTR_W-1 -: 3], feeding the control unit's OpCode input.

Function
REQ-017 SHALL implement FSM states IDLE, REQ, HOLD; encoding is free.
REQ-018 SHALL leave IDLE for REQ one cycle after reset release, unconditionally.
REQ-019 In REQ SHALL drive imem_req=1 and imem_addr=pc, both held stable until imem_ack or redirect.
REQ-020 On imem_ack in REQ SHALL capture imem_rdata into instr and pc into instr_pc, set pc=pc+1 modulo 2^PC_W, and enter HOLD; instr_valid rises the following cycle (1-cycle latency).
REQ-021 In HOLD SHALL drive instr_valid=1 and imem_req=0, holding instr, instr_pc and op_code stable until instr_ready.
REQ-022 On instr_valid && instr_ready SHALL enter REQ; instr_valid is 0 the next cycle.
REQ-023 SHALL wrap pc from 2^PC_W-1 to 0 without error.
REQ-024 SHALL give redirect_valid highest priority in every non-reset state: next cycle pc=redirect_pc, instr_valid=0, state REQ.
REQ-025 SHALL discard an imem_ack or instr_ready coinciding with redirect_valid; no instruction is captured or consumed.
REQ-026 SHALL give rst priority over redirect_valid.

Reset
REQ-027 On rst SHALL set state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, op_code=0.
REQ-028 Reset asserted mid-request SHALL drop imem_req the next cycle; an imem_ack in that cycle is ignored.

Configuration
REQ-029 Macro FETCH_PREFETCH_EN SHALL select prefetch mode.
REQ-030 Without FETCH_PREFETCH_EN SHALL have at most one instruction in flight or held, per REQ-017..REQ-022 (peak 1 instruction per 2 cycles).
REQ-031 With FETCH_PREFETCH_EN SHALL place a 2-entry FIFO between memory and output; imem_req=1 while FIFO count<2; instr_valid=(count!=0); instr, instr_pc = FIFO head.
REQ-032 In prefetch mode, simultaneous push and pop SHALL leave count unchanged; with count=2, imem_req=0.
REQ-033 In prefetch mode, redirect_valid SHALL empty the FIFO in the same edge.

Structure
REQ-034 Shared package fetch_pkg SHALL hold PC_W/INSTR_W defaults, opcode field position, opcode constants (OP_LOAD=3'b000, OP_STORE=3'b100) and the FSM state type.
REQ-035 Prefetch FIFO SHALL be sub-module fetch_buffer, instantiated only under FETCH_PREFETCH_EN.

Verification
REQ-036 Reset then imem_ack every request with rdata=16'h8000|addr, ready=1 -> instr_pc sequence 0,1,2,...; op_code=3'b100 on every beat.
REQ-037 Hold instr_ready=0 for 5 cycles in HOLD -> instr, instr_pc, instr_valid unchanged; no imem_req.
REQ-038 RESET_PC=8'hFE, fetch 3 instructions -> instr_pc 8'hFE, 8'hFF, 8'h00.
REQ-039 redirect_valid with redirect_pc=8'h40 in the same cycle as imem_ack -> ack data dropped; next imem_addr=8'h40; instr_valid=0.
REQ-040 rst pulsed while imem_req=1 -> next cycle imem_req=0, instr_valid=0; fetch restarts at RESET_PC.
REQ-041 With FETCH_PREFETCH_EN, ack every cycle, ready=0 -> two acks accepted, then imem_req=0; ready=1 drains in order.
